fifo_rd_stream: RTL

//  Read-side drain stage sitting directly downstream of synchronous_fifo.
//  - Issues r_en into the FIFO and captures its registered data_out.
//  - Presents the words as a valid/ready stream with packet framing (m_last).
//  - Sustains 1 beat/clk with no combinational path from m_ready to fifo_r_en.

---
 rtl/fifo_stream_pkg.sv | 11 +
 rtl/fifo_rd_skid.sv | 72 +++++++
 rtl/fifo_rd_stream.sv | 91 +++++++++
 3 files changed

// File: rtl/fifo_stream_pkg.sv
// Shared types and constants for the FIFO read-side streaming stage.
// Imported by the holding buffer and the top level.
package fifo_stream_pkg;

    localparam int DEFAULT_DATA_W = 8;
    localparam int MIN_BUF_DEPTH  = 3;
    localparam int MAX_PKT_LEN    = 65535;

    typedef logic [DEFAULT_DATA_W-1:0] word_t;

endpackage

// File: rtl/fifo_rd_skid.sv
// Circular holding buffer between the FIFO read port and the output stream.
// The pointers wrap modulo BUF_DEPTH, so the depth does not have to be a power of two.
module fifo_rd_skid
    import fifo_stream_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int BUF_DEPTH = MIN_BUF_DEPTH,
    parameter int OCC_W     = $clog2(BUF_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic [OCC_W-1:0]  occ
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

    logic [DATA_W-1:0] mem_q [BUF_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic              pop_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(BUF_DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    // The issue rule upstream guarantees a free slot for every push.
    always_comb begin
        pop_ok   = pop && (occ_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop_ok) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push, pop_ok})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // NOTE: storage is not reset; an entry is only observable after it has been written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign occ       = occ_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains a registered-output synchronous FIFO into a valid/ready stream with
// packet framing; r_en depends only on local registers and fifo_empty.
module fifo_rd_stream
    import fifo_stream_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int BUF_DEPTH = MIN_BUF_DEPTH,
    parameter int PKT_LEN   = 4,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data_out,
    output logic              fifo_r_en,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int OCC_W  = $clog2(BUF_DEPTH + 1);
    localparam int BEAT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

    generate
        if (BUF_DEPTH < MIN_BUF_DEPTH) begin : g_bad_depth
            $error("fifo_rd_stream: BUF_DEPTH below minimum for full throughput");
        end
        if (PKT_LEN < 1 || PKT_LEN > MAX_PKT_LEN) begin : g_bad_pkt_len
            $error("fifo_rd_stream: PKT_LEN out of range");
        end
    endgenerate

    logic [OCC_W-1:0]  occ;
    logic [DATA_W-1:0] head_data;
    logic              handshake;
    logic              inflight_q, inflight_d;
    logic [BEAT_W-1:0] beat_idx_q, beat_idx_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    fifo_rd_skid #(
        .DATA_W    (DATA_W),
        .BUF_DEPTH (BUF_DEPTH),
        .OCC_W     (OCC_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_q),
        .push_data (fifo_data_out),
        .pop       (handshake),
        .head_data (head_data),
        .occ       (occ)
    );

    // Counting the in-flight read reserves its slot, so the buffer can never overflow.
    always_comb begin
        fifo_r_en = !rst && !fifo_empty
                    && ((int'(occ) + int'(inflight_q)) < BUF_DEPTH);
        m_valid   = (occ != '0);
        handshake = m_valid && m_ready;
        m_data    = m_valid ? head_data : '0;
        m_last    = m_valid && (beat_idx_q == BEAT_W'(PKT_LEN - 1));

        inflight_d  = fifo_r_en;
        beat_idx_d  = beat_idx_q;
        stall_cnt_d = stall_cnt_q;
        if (handshake) begin
            beat_idx_d = (beat_idx_q == BEAT_W'(PKT_LEN - 1)) ? '0 : beat_idx_q + BEAT_W'(1);
        end
        if (m_valid && !m_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q  <= 1'b0;
            beat_idx_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            inflight_q  <= inflight_d;
            beat_idx_q  <= beat_idx_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule
